// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the memory arbiter and its clients.
//   ramstate_t  : status reported by the RAM each cycle
//   arb_state_t : arbiter grant state (IDLE / IGRANT / DGRANT)
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
// Shares one RAM port between an instruction fetch requester and a data
// requester. Data normally wins. However, once STARVE_MAX data accesses in a
// row have completed while an instruction fetch was pending, the next grant
// goes to the instruction side.
//
// Ports
//   CLK, nRST              clock, async active-low reset
//   iREN, iaddr            instruction read request / word address
//   iwait, iload           instruction stall (low on completion) / read data
//   dREN, dWEN             data read / write request (write wins if both)
//   daddr, dstore          data address / write value
//   dwait, dload           data stall (low on completion) / read data
//   ramREN, ramWEN         RAM read / write strobes
//   ramaddr, ramstore      RAM address / write data
//   ramload, ramstate      RAM read data / RAM status
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no grant; RAM strobes low; picks the next requester
// IGRANT | instruction fetch drives the RAM until ACCESS or abort
// DGRANT | data request drives the RAM until ACCESS or abort
// ---------------------------------------------------------------------------
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Both read-data paths are straight wires from the RAM; the waits tell
  // each requester when its copy is meaningful.
  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;

    case (state)
      IDLE: begin
        if (dREN | dWEN) begin
          if (iREN && (starve_cnt == STARVE_LIM)) state_nxt = IGRANT;
          else                                    state_nxt = DGRANT;
        end else if (iREN) begin
          state_nxt = IGRANT;
        end
      end

      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramstate == ACCESS) begin
          iwait      = 1'b0;
          state_nxt  = IDLE;
          starve_nxt = '0;
        end else if (!iREN) begin
          // requester gave up before the RAM answered
          state_nxt = IDLE;
        end
      end

      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ramstate == ACCESS) begin
          dwait     = 1'b0;
          state_nxt = IDLE;
          // count only data wins that actually made a fetch wait
          if (!iREN)                          starve_nxt = '0;
          else if (starve_cnt != STARVE_LIM)  starve_nxt = starve_cnt + 1'b1;
        end else if (!(dREN | dWEN)) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  memory_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        is_i;
    logic [31:0] data;
  } done_t;

  done_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_done(input logic is_i, input logic [31:0] data);
    done_t e;
    e.is_i = is_i;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // completion monitor: every wait-low cycle must match a queued expectation
  always @(negedge CLK) begin
    if (!iwait || !dwait) begin
      done_t e;
      chk("done_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      chk("single_wait", {31'd0, iwait | dwait}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("done_port_i", {31'd0, !iwait}, {31'd0, e.is_i});
        chk("done_load", e.is_i ? iload : dload, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   exp_cnt;
  logic exp_i;

  initial begin
    nRST = 1'b0;
    iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;
    iaddr = 32'h4; daddr = 32'h8; dstore = 32'hFFFF; ramload = 32'h0;
    ramstate = ACCESS;
    #1;
    // requests asserted during reset must not reach the RAM
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    cyc();
    chk("rst_hold_ramWEN", {31'd0, ramWEN}, 32'd0);
    iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    cyc();
    nRST = 1'b1;
    cyc();

    // instruction read with two BUSY cycles
    iREN = 1'b1; iaddr = 32'h40;
    cyc();
    chk("ifetch_ramREN", {31'd0, ramREN}, 32'd1);
    chk("ifetch_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("ifetch_ramaddr", ramaddr, 32'h40);
    ramstate = BUSY;
    cyc();
    chk("ifetch_busy_iwait", {31'd0, iwait}, 32'd1);
    cyc();
    chk("ifetch_busy2_iwait", {31'd0, iwait}, 32'd1);
    ramstate = ACCESS; ramload = 32'h8C010004;
    push_done(1'b1, 32'h8C010004);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    #1;
    chk("ifetch_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("ifetch_idle_iwait", {31'd0, iwait}, 32'd1);
    cyc();

    // simultaneous instruction + data write: data first, then instruction
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD;
    cyc();
    chk("sim_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("sim_ramREN", {31'd0, ramREN}, 32'd0);
    chk("sim_ramaddr", ramaddr, 32'h100);
    chk("sim_ramstore", ramstore, 32'hDEAD);
    ramstate = ACCESS; ramload = 32'h11112222;
    push_done(1'b0, 32'h11112222);
    cyc();
    dWEN = 1'b0; ramstate = FREE;
    #1;
    chk("sim_gap_ramREN", {31'd0, ramREN}, 32'd0);
    chk("sim_gap_ramWEN", {31'd0, ramWEN}, 32'd0);
    cyc();
    chk("sim_igrant_ramREN", {31'd0, ramREN}, 32'd1);
    chk("sim_igrant_ramaddr", ramaddr, 32'h80);
    chk("sim_igrant_ramstore", ramstore, 32'd0);
    ramstate = ACCESS; ramload = 32'h33334444;
    push_done(1'b1, 32'h33334444);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    cyc();

    // starvation: both requesters held continuously
    exp_cnt = 0;
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300;
    for (int r = 0; r < 6; r++) begin
      cyc();
      exp_i = (exp_cnt == STARVE_MAX);
      chk("starve_ramaddr", ramaddr, exp_i ? 32'h200 : 32'h300);
      chk("starve_ramREN", {31'd0, ramREN}, 32'd1);
      ramstate = ACCESS; ramload = 32'h1000 + r;
      push_done(exp_i, 32'h1000 + r);
      cyc();
      ramstate = FREE;
      if (exp_i) begin
        exp_cnt = 0;
        chk("starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
      end else if (exp_cnt < STARVE_MAX) begin
        exp_cnt++;
      end
    end
    iREN = 1'b0; dREN = 1'b0;
    cyc();
    cyc();

    // write wins when both data strobes are high
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h10; dstore = 32'h5;
    cyc();
    chk("wwin_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("wwin_ramREN", {31'd0, ramREN}, 32'd0);
    ramstate = ACCESS; ramload = 32'h0BAD0BAD;
    push_done(1'b0, 32'h0BAD0BAD);
    cyc();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    cyc();

    // error retry on a data read, with a FREE cycle holding the grant first
    dREN = 1'b1; daddr = 32'h44;
    cyc();
    chk("err_ramREN", {31'd0, ramREN}, 32'd1);
    ramstate = FREE;
    cyc();
    chk("err_free_hold", {31'd0, ramREN}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      ramstate = ERROR;
      cyc();
      chk("err_dwait", {31'd0, dwait}, 32'd1);
      chk("err_hold_addr", ramaddr, 32'h44);
    end
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    push_done(1'b0, 32'hCAFEF00D);
    cyc();
    dREN = 1'b0; ramstate = FREE;
    cyc();

    // abort: dREN dropped during BUSY, no dwait pulse
    dREN = 1'b1; daddr = 32'h50;
    cyc();
    ramstate = BUSY;
    cyc();
    chk("abort_busy_dwait", {31'd0, dwait}, 32'd1);
    dREN = 1'b0;
    cyc();
    chk("abort_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("abort_idle_ramaddr", ramaddr, 32'd0);
    ramstate = ACCESS;
    cyc();
    chk("abort_no_pulse", {31'd0, dwait}, 32'd1);
    ramstate = FREE;
    cyc();

    // bump the counter, then reset in the middle of an instruction grant
    iREN = 1'b1; iaddr = 32'h60; dREN = 1'b1; daddr = 32'h70;
    cyc();
    chk("rstmid_dgrant_addr", ramaddr, 32'h70);
    ramstate = ACCESS; ramload = 32'h77;
    push_done(1'b0, 32'h77);
    cyc();
    dREN = 1'b0; ramstate = FREE;
    chk("rstmid_cnt_one", 32'(dut.starve_cnt), 32'd1);
    cyc();
    chk("rstmid_igrant_ramREN", {31'd0, ramREN}, 32'd1);
    ramstate = BUSY;
    #2;
    nRST = 1'b0;
    #1;
    chk("rstmid_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rstmid_ramaddr", ramaddr, 32'd0);
    chk("rstmid_iwait", {31'd0, iwait}, 32'd1);
    chk("rstmid_dwait", {31'd0, dwait}, 32'd1);
    chk("rstmid_cnt", 32'(dut.starve_cnt), 32'd0);
    ramstate = ACCESS;
    cyc();
    chk("rstmid_hold_iwait", {31'd0, iwait}, 32'd1);
    iREN = 1'b0; ramstate = FREE;
    nRST = 1'b1;
    cyc();
    cyc();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
